// File: rtl/instr_encode_loader.sv
// Instruction loader: encodes symbolic requests into MIPS words, buffers them in a small FIFO
// and writes them sequentially into instruction memory starting at a programmed base address.
module instr_encode_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_next;

  logic [32:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           fifo_empty, fifo_full;
  logic [32:0]    head;
  logic           head_last;
  logic [31:0]    enc_word;
  logic           last_accepted;
  logic           push, pop, start_take, go_err;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign head_last  = head[32];

  assign push       = (state == S_LOAD) && req_valid && req_ready;
  assign pop        = imem_we && imem_ready;
  assign start_take = start && ((state == S_IDLE) || (state == S_ERR));
  // A non-final word landing on the top address would wrap on the next write
  assign go_err     = (state == S_LOAD) && pop && !head_last && (imem_addr == '1);

  always_comb begin
    enc_word = '0;
    case (req_kind)
      3'd0:    enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100000};
      3'd1:    enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100010};
      3'd2:    enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100100};
      3'd3:    enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100101};
      3'd4:    enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b101010};
      3'd5:    enc_word = {6'b100011, req_rs, req_rt, req_imm};
      3'd6:    enc_word = {6'b101011, req_rs, req_rt, req_imm};
      default: enc_word = {6'b000100, req_rs, req_rt, req_imm};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_LOAD;
      S_LOAD: begin
        if (pop) begin
          if (head_last)              state_next = S_DONE;
          else if (imem_addr == '1)   state_next = S_ERR;
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   if (start) state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    imem_we    = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_LOAD: begin
        req_ready = !fifo_full && !last_accepted;
        imem_we   = !fifo_empty;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
    imem_wdata = imem_we ? head[31:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {req_last, enc_word};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      imem_addr     <= '0;
      count         <= '0;
      last_accepted <= 1'b0;
    end else if (start_take) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      imem_addr     <= base_addr;
      count         <= '0;
      last_accepted <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
        if (req_last) last_accepted <= 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + (PTR_W+1)'(1);
        imem_addr <= imem_addr + ADDR_W'(1);
        count     <= count + (ADDR_W+1)'(1);
      end
      // Entering the error state discards anything still buffered, including a same-cycle push
      if (go_err) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader: table vectors, multi-cycle corner sequences
// and randomized sessions checked against a queue-based reference model.
module tb_instr_encode_loader;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        last;
  } req_t;

  typedef struct {
    logic [7:0]  base;
    req_t        r;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] word;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_kind = '0;
  logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0;
  logic [15:0] req_imm = '0;
  logic        req_last = 1'b0;
  logic        imem_we;
  logic        imem_ready = 1'b0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err;
  logic [8:0]  count;

  int checks = 0;
  int errors = 0;

  req_t        sess_q[$];
  wr_t         exp_q[$];
  logic [7:0]  exp_addr = '0;
  int          acc_cnt = 0;
  logic [7:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;
  bit          rand_rdy = 0;

  instr_encode_loader #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .req_last(req_last), .imem_we(imem_we), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
    .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Reference encoder from the field layout with plain arithmetic
  function automatic logic [31:0] model_encode(input req_t r);
    logic [31:0] f, op;
    if (r.kind <= 3'd4) begin
      case (r.kind)
        3'd0:    f = 32;
        3'd1:    f = 34;
        3'd2:    f = 36;
        3'd3:    f = 37;
        default: f = 42;
      endcase
      return 32'(r.rs) * (2**21) + 32'(r.rt) * (2**16) + 32'(r.rd) * (2**11) + f;
    end
    case (r.kind)
      3'd5:    op = 35;
      3'd6:    op = 43;
      default: op = 4;
    endcase
    return op * (2**26) + 32'(r.rs) * (2**21) + 32'(r.rt) * (2**16) + 32'(r.imm);
  endfunction

  function automatic req_t mkreq(input int kind, input int rs, input int rt, input int rd,
                                 input int imm, input bit last);
    req_t r;
    r.kind = 3'(kind); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
    r.imm = 16'(imm); r.last = last;
    return r;
  endfunction

  function automatic req_t rndreq(input bit last);
    return mkreq($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 65535), last);
  endfunction

  function automatic vec_t mkvec(input logic [7:0] base, input req_t r, input logic [31:0] word);
    vec_t v;
    v.base = base; v.r = r; v.word = word;
    return v;
  endfunction

  // Write monitor: checks every memory write against the expected-write queue
  initial begin
    bit prev_stall = 0;
    logic [7:0] s_addr;
    logic [31:0] s_data;
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 0;
      else begin
        if (prev_stall) chk("stall_hold", {imem_we, imem_addr, imem_wdata}, {1'b1, s_addr, s_data});
        if (imem_we && imem_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL write_extra actual=addr %0h data %0h expected=no write", imem_addr, imem_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", imem_addr, e.addr);
            chk("wr_data", imem_wdata, e.word);
          end
          last_waddr = imem_addr;
          last_wdata = imem_wdata;
        end
        prev_stall = imem_we && !imem_ready;
        s_addr = imem_addr;
        s_data = imem_wdata;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) imem_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // All driver tasks enter and leave aligned 2 time units after a rising edge
  task automatic do_start(input logic [7:0] b);
    start = 1'b1;
    base_addr = b;
    exp_addr = b;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic feed(input bit gaps);
    req_t r;
    bit got;
    while (sess_q.size() > 0) begin
      r = sess_q.pop_front();
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
      req_kind = r.kind; req_rs = r.rs; req_rt = r.rt; req_rd = r.rd;
      req_imm = r.imm; req_last = r.last; req_valid = 1'b1;
      got = 0;
      for (int t = 0; t < 300 && !got; t++) begin
        @(negedge clk);
        if (req_ready) begin
          got = 1;
          acc_cnt++;
          exp_q.push_back('{exp_addr, model_encode(r)});
          exp_addr = exp_addr + 8'd1;
        end
        @(posedge clk); #2;
      end
      req_valid = 1'b0;
      if (!got) begin
        fail_now("accept");
        sess_q.delete();
      end
    end
  endtask

  task automatic wait_done(input int n_exp, input string tag);
    bit seen = 0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        chk({tag, "_count"}, count, n_exp);
        chk({tag, "_done_quiet"}, {imem_we, req_ready, busy}, 3'b001);
      end
      @(posedge clk); #2;
    end
    if (!seen) fail_now({tag, "_done"});
    else begin
      @(negedge clk);
      chk({tag, "_done_pulse"}, {done, busy}, 2'b00);
      chk({tag, "_count_hold"}, count, n_exp);
      chk({tag, "_drained"}, exp_q.size(), 0);
      @(posedge clk); #2;
    end
  endtask

  initial begin
    vec_t vt[9];
    int n;
    bit seen;
    logic [7:0] b;

    vt[0] = mkvec(8'h10, mkreq(0, 1, 2, 3, 0, 1),        32'h00221820);
    vt[1] = mkvec(8'h20, mkreq(1, 4, 5, 6, 0, 1),        32'h00853022);
    vt[2] = mkvec(8'h21, mkreq(2, 31, 31, 31, 0, 1),     32'h03FFF824);
    vt[3] = mkvec(8'h22, mkreq(3, 0, 0, 0, 0, 1),        32'h00000025);
    vt[4] = mkvec(8'h23, mkreq(4, 7, 9, 10, 0, 1),       32'h00E9502A);
    vt[5] = mkvec(8'h24, mkreq(5, 29, 8, 31, 4, 1),      32'h8FA80004);
    vt[6] = mkvec(8'h25, mkreq(6, 29, 8, 0, 4, 1),       32'hAFA80004);
    vt[7] = mkvec(8'h26, mkreq(7, 1, 2, 0, 16'hFFFF, 1), 32'h1022FFFF);
    vt[8] = mkvec(8'hFF, mkreq(0, 1, 2, 3, 16'hABCD, 1), 32'h00221820);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {req_ready, imem_we, busy, done, err}, 5'b0);
    chk("rst_data", {imem_addr, count, imem_wdata}, '0);
    #3 rst_n = 1'b1;
    @(posedge clk); #2;
    imem_ready = 1'b1;

    // Single-instruction sessions from the vector table
    foreach (vt[i]) begin
      do_start(vt[i].base);
      sess_q.push_back(vt[i].r);
      feed(0);
      wait_done(1, "tbl");
      chk("tbl_word", last_wdata, vt[i].word);
      chk("tbl_addr", last_waddr, vt[i].base);
      chk("tbl_err", err, 1'b0);
    end

    // LW / SW / BEQ(last) at consecutive addresses
    do_start(8'h30);
    sess_q.push_back(mkreq(5, 29, 8, 0, 4, 0));
    sess_q.push_back(mkreq(6, 29, 8, 0, 4, 0));
    sess_q.push_back(mkreq(7, 1, 2, 0, 16'hFFFF, 1));
    feed(0);
    wait_done(3, "seq3");
    chk("seq3_last_word", last_wdata, 32'h1022FFFF);
    chk("seq3_last_addr", last_waddr, 8'h32);

    // Backpressure: four fit in the buffer, fifth waits for memory
    imem_ready = 1'b0;
    acc_cnt = 0;
    do_start(8'h50);
    sess_q.push_back(mkreq(0, 1, 2, 3, 0, 0));
    for (int i = 0; i < 3; i++) sess_q.push_back(rndreq(0));
    sess_q.push_back(rndreq(1));
    fork
      feed(0);
      begin
        start = 1'b1;
        base_addr = 8'h99;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("bp_accepted", acc_cnt, 4);
        chk("bp_ready_low", req_ready, 1'b0);
        chk("bp_head", {imem_we, imem_addr, imem_wdata}, {1'b1, 8'h50, 32'h00221820});
        @(posedge clk); #2;
        imem_ready = 1'b1;
      end
    join
    wait_done(5, "bp");
    chk("bp_total", acc_cnt, 5);

    // Address exhaustion at the top of the address space
    do_start(8'hFE);
    for (int i = 0; i < 3; i++) sess_q.push_back(rndreq(0));
    feed(0);
    seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (err) begin
        seen = 1;
        chk("err_state", {err, imem_we, req_ready, busy}, 4'b1001);
        chk("err_count", count, 2);
        chk("err_last_addr", last_waddr, 8'hFF);
      end
      @(posedge clk); #2;
    end
    if (!seen) fail_now("err_raise");
    exp_q.delete();
    repeat (4) begin
      @(negedge clk);
      chk("err_sticky", {err, imem_we}, 2'b10);
    end
    @(posedge clk); #2;
    do_start(8'h00);
    @(negedge clk);
    chk("err_clear", {err, busy, count}, {1'b0, 1'b1, 9'd0});
    @(posedge clk); #2;
    sess_q.push_back(rndreq(0));
    sess_q.push_back(rndreq(1));
    feed(0);
    wait_done(2, "after_err");
    chk("after_err_addr", last_waddr, 8'h01);

    // Reset with words buffered and a write pending
    imem_ready = 1'b0;
    do_start(8'h40);
    for (int i = 0; i < 3; i++) sess_q.push_back(rndreq(0));
    feed(0);
    @(negedge clk);
    chk("pre_rst_we", {imem_we, busy}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {imem_we, busy, req_ready, done, err}, 5'b0);
    chk("mid_rst_data", {imem_addr, count, imem_wdata}, '0);
    exp_q.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    imem_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_idle", {imem_we, busy}, 2'b00);
    end
    @(posedge clk); #2;

    // Randomized sessions with random gaps and memory backpressure
    rand_rdy = 1;
    for (int s = 0; s < 8; s++) begin
      n = $urandom_range(1, 12);
      b = 8'($urandom_range(0, 200));
      do_start(b);
      for (int i = 0; i < n; i++) sess_q.push_back(rndreq(i == n - 1));
      feed(1);
      wait_done(n, "rnd");
      chk("rnd_last_addr", last_waddr, b + 8'(n - 1));
    end
    rand_rdy = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
